// File: rtl/s_to_t_stream.sv
// Streaming sign-magnitude to two's-complement converter.
// Two register stages (S1: raw sample, S2: converted result) with valid/ready
// flow control. Out-of-range magnitudes are clamped. Saturation and
// negative-zero events are counted when the sample is delivered downstream.
module s_to_t_stream #(
  parameter int SM_W  = 8,
  parameter int TC_W  = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SM_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TC_W-1:0]  out_data,
  output logic             out_sat,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sat_cnt,
  output logic [CNT_W-1:0] nz_cnt
);

  // Limits expressed at SM_W width so they can be compared against the
  // zero-extended magnitude even when TC_W == SM_W.
  localparam logic [SM_W-1:0]  ONE     = SM_W'(1);
  localparam logic [SM_W-1:0]  MAXN    = ONE << (TC_W - 1);
  localparam logic [SM_W-1:0]  MAXP    = MAXN - ONE;
  localparam logic [TC_W-1:0]  TC_MAXP = {1'b0, {(TC_W-1){1'b1}}};
  localparam logic [TC_W-1:0]  TC_MAXN = {1'b1, {(TC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            s1_valid;
  logic [SM_W-1:0] s1_data;
  logic            s2_valid;
  logic            s2_nz;
  logic            s2_adv;
  logic            s1_adv;
  logic            out_xfer;

  logic            sign;
  logic [SM_W-1:0] mag_ext;
  logic [TC_W-1:0] mag_lo;
  logic [TC_W-1:0] cv_data;
  logic            cv_sat;
  logic            cv_nz;

  assign s2_adv    = !s2_valid | out_ready;
  assign s1_adv    = s1_valid & s2_adv;
  assign in_ready  = !s1_valid | s2_adv;
  assign out_valid = s2_valid;
  assign out_xfer  = s2_valid & out_ready;

  assign sign    = s1_data[SM_W-1];
  assign mag_ext = {1'b0, s1_data[SM_W-2:0]};
  assign mag_lo  = mag_ext[TC_W-1:0];

  // Convert the S1 sample; negation of MAXN wraps to the most-negative code.
  always_comb begin
    cv_data = mag_lo;
    cv_sat  = 1'b0;
    cv_nz   = 1'b0;
    if (!sign) begin
      if (mag_ext > MAXP) begin
        cv_data = TC_MAXP;
        cv_sat  = 1'b1;
      end
    end else if (mag_ext == '0) begin
      cv_data = '0;
      cv_nz   = 1'b1;
    end else if (mag_ext > MAXN) begin
      cv_data = TC_MAXN;
      cv_sat  = 1'b1;
    end else begin
      cv_data = -mag_lo;
    end
  end

  // S1: capture the accepted input sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= in_data;
    end
  end

  // S2: register the converted result; held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
      s2_nz    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_adv) begin
        out_data <= cv_data;
        out_sat  <= cv_sat;
        s2_nz    <= cv_nz;
      end
    end
  end

  // Event counters: bump on delivery, stick at all-ones, clear has priority.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sat_cnt <= '0;
      nz_cnt  <= '0;
    end else if (out_xfer) begin
      if (out_sat && sat_cnt != CNT_MAX) sat_cnt <= sat_cnt + 1'b1;
      if (s2_nz   && nz_cnt  != CNT_MAX) nz_cnt  <= nz_cnt  + 1'b1;
    end
  end

endmodule

// File: tb/tb_s_to_t_stream.sv
// Bench for s_to_t_stream: directed conversion/backpressure/reset steps then
// randomized traffic, checked against an integer-arithmetic reference model.
module tb_s_to_t_stream;

  localparam int SM_W  = 8;
  localparam int TC_W  = 7;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SM_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [TC_W-1:0]  out_data;
  logic             out_sat;
  logic             cnt_clr;
  logic [CNT_W-1:0] sat_cnt;
  logic [CNT_W-1:0] nz_cnt;

  s_to_t_stream #(.SM_W(SM_W), .TC_W(TC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .cnt_clr(cnt_clr), .sat_cnt(sat_cnt), .nz_cnt(nz_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Expected entries: {nz, sat, data[6:0]}
  logic [8:0]       q[$];
  logic [CNT_W-1:0] m_sat = '0;
  logic [CNT_W-1:0] m_nz  = '0;
  bit               stall_p = 1'b0;
  logic [7:0]       stall_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed value, clamp into the TC_W range.
  function automatic logic [8:0] ref_conv(input logic [7:0] sm);
    int v;
    bit s;
    bit nz;
    v  = int'(sm[6:0]);
    if (sm[7]) v = -v;
    s  = 1'b0;
    if (v > 63)  begin v = 63;  s = 1'b1; end
    if (v < -64) begin v = -64; s = 1'b1; end
    nz = (sm == 8'h80);
    return {nz, s, 7'(v)};
  endfunction

  // One clock: observe transfers at the falling edge, update the model,
  // then check counters just after the rising edge.
  task automatic tick(output bit it, output bit ot, output logic [6:0] od);
    logic [8:0] e;
    @(negedge clk);
    it = 1'b0;
    ot = 1'b0;
    od = out_data;
    if (rst) begin
      q.delete();
      m_sat = '0;
      m_nz = '0;
      stall_p = 1'b0;
    end else begin
      it = in_valid && in_ready;
      ot = out_valid && out_ready;
      if (stall_p) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({out_sat, out_data}), 32'(stall_d));
      end
      stall_p = out_valid && !out_ready;
      stall_d = {out_sat, out_data};
      e = '0;
      if (ot) begin
        if (q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
        else begin
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e[6:0]));
          chk("out_sat", 32'(out_sat), 32'(e[7]));
        end
      end
      if (cnt_clr) begin
        m_sat = '0;
        m_nz = '0;
      end else if (ot) begin
        if (e[7] && m_sat != '1) m_sat++;
        if (e[8] && m_nz != '1) m_nz++;
      end
      if (it) q.push_back(ref_conv(in_data));
    end
    @(posedge clk);
    #1;
    chk("sat_cnt", 32'(sat_cnt), 32'(m_sat));
    chk("nz_cnt", 32'(nz_cnt), 32'(m_nz));
  endtask

  task automatic step();
    bit a, b;
    logic [6:0] d;
    tick(a, b, d);
  endtask

  // Send one sample with no backpressure and check it two edges later.
  task automatic conv_check(input string tag, input logic [7:0] d,
                            input logic [6:0] exp, input bit exps);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    chk({tag, "_sat"}, 32'(out_sat), 32'(exps));
    step();
  endtask

  initial begin
    bit a, b;
    logic [6:0] d;
    int k, ndel, lastc;
    logic [7:0] picks [8];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("rst_nz_cnt", 32'(nz_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    conv_check("p44", 8'b0_0101100, 7'b0101100, 1'b0);
    conv_check("n44", 8'b1_0101100, 7'b1010100, 1'b0);
    conv_check("n64", 8'b1_1000000, 7'b1000000, 1'b0);
    conv_check("n65", 8'b1_1000001, 7'b1000000, 1'b1);
    conv_check("p64", 8'b0_1000000, 7'b0111111, 1'b1);
    chk("sat_cnt_2", 32'(sat_cnt), 32'd2);

    conv_check("nz", 8'b1_0000000, 7'd0, 1'b0);
    chk("nz_cnt_1", 32'(nz_cnt), 32'd1);
    in_valid = 1'b1; in_data = 8'h80;
    step();
    in_valid = 1'b0;
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("nz_clr_wins", 32'(nz_cnt), 32'd0);

    // Backpressure: five samples, downstream stalled for the first 4 cycles.
    k = 0; ndel = 0; lastc = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 4);
      in_valid  = (k < 5);
      in_data   = 8'(k + 1);
      if (c == 2 || c == 3) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold", 32'(out_data), 32'd1);
      end
      tick(a, b, d);
      if (a) k++;
      if (b) begin
        chk("bp_order", 32'(d), 32'(ndel + 1));
        if (ndel > 0) chk("bp_gap", 32'(c), 32'(lastc + 1));
        lastc = c;
        ndel++;
      end
    end
    in_valid = 1'b0;
    chk("bp_count", 32'(ndel), 32'd5);

    // Reset with both stages full and a non-zero counter.
    conv_check("rs_pre", 8'h41, 7'h3f, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hC5;
    step();
    in_data = 8'h80;
    step();
    in_valid = 1'b0;
    chk("rs_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_out_data", 32'(out_data), 32'd0);
    chk("rs_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("rs_nz_cnt", 32'(nz_cnt), 32'd0);
    chk("rs_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("rs_stale", 32'(out_valid), 32'd0);
      step();
    end

    // Randomized traffic with a bias toward boundary codes.
    picks = '{8'h00, 8'h80, 8'h3F, 8'h40, 8'hBF, 8'hC0, 8'hC1, 8'hFF};
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) in_data = picks[$urandom_range(0, 7)];
      else in_data = 8'($urandom);
      cnt_clr = ($urandom_range(0, 24) == 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
